// File: rtl/packet_aware_fifo_sc.sv
// Single-clock packet-aware width-converting FIFO: wide words in, narrow words out, read side sees committed packets only.
// Optional rollback of the open packet is built when PKT_ABORT_EN is defined.
module packet_aware_fifo_sc #(
    parameter int IN_WIDTH   = 64,
    parameter int OUT_WIDTH  = 16,
    parameter int DEPTH_LOG2 = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_WIDTH-1:0]   din,
    input  logic                  wr_en,
    input  logic                  pkt_end,
    input  logic                  pkt_abort,
    output logic                  full,
    input  logic                  rd_en,
    output logic [OUT_WIDTH-1:0]  dout,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   output_size
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int PTR_W = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [OUT_WIDTH-1:0] r_ram [DEPTH];
    logic [PTR_W-1:0]     r_wrPtr;
    logic [PTR_W-1:0]     r_cmtPtr;
    logic [PTR_W-1:0]     r_rdPtr;
    logic                 r_outValid;
    logic [OUT_WIDTH-1:0] r_dout;

    logic                 w_wrAccept;
    logic                 w_pop;
    logic                 w_fetch;
    logic [PTR_W-1:0]     w_used;
    logic [PTR_W-1:0]     w_free;
    logic [PTR_W-1:0]     w_nextWrPtr;

    // The word held in the output register still counts as occupied space.
    assign w_used      = r_wrPtr - r_rdPtr + PTR_W'(r_outValid);
    assign w_free      = PTR_W'(DEPTH) - w_used;
    assign full        = w_free < PTR_W'(RATIO);
    assign w_nextWrPtr = r_wrPtr + PTR_W'(RATIO);

`ifdef PKT_ABORT_EN
    assign w_wrAccept = wr_en & ~full & ~pkt_abort;
`else
    assign w_wrAccept = wr_en & ~full;
    logic w_unused_abort;
    assign w_unused_abort = pkt_abort;
`endif

    assign w_pop   = rd_en & r_outValid;
    assign w_fetch = (~r_outValid | w_pop) & (r_cmtPtr != r_rdPtr);

    assign dout        = r_dout;
    assign empty       = ~r_outValid;
    assign output_size = r_cmtPtr - r_rdPtr + PTR_W'(r_outValid);

    always_ff @(posedge clk) begin
        if (w_wrAccept) begin
            for (int k = 0; k < RATIO; k++) begin
                r_ram[r_wrPtr[DEPTH_LOG2-1:0] + DEPTH_LOG2'(k)] <= din[IN_WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr  <= '0;
            r_cmtPtr <= '0;
        end else begin
`ifdef PKT_ABORT_EN
            if (pkt_abort) begin
                r_wrPtr <= r_cmtPtr;
            end else
`endif
            if (w_wrAccept) begin
                r_wrPtr <= w_nextWrPtr;
                if (pkt_end) begin
                    r_cmtPtr <= w_nextWrPtr;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdPtr    <= '0;
            r_outValid <= 1'b0;
            r_dout     <= '0;
        end else if (w_fetch) begin
            r_dout     <= r_ram[r_rdPtr[DEPTH_LOG2-1:0]];
            r_rdPtr    <= r_rdPtr + PTR_W'(1);
            r_outValid <= 1'b1;
        end else if (w_pop) begin
            r_outValid <= 1'b0;
        end
    end

endmodule
